// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel request side and serial line of the UART transmitter
//   P_DATA, data_valid, PAR_EN, PAR_TYP : producer -> transmitter
//   TX_out, busy                        : transmitter -> line / producer
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic data_valid;
  logic PAR_EN;
  logic PAR_TYP;
  logic TX_out;
  logic busy;
  modport master (output P_DATA, data_valid, PAR_EN, PAR_TYP, input TX_out, busy);
  modport slave (input P_DATA, data_valid, PAR_EN, PAR_TYP, output TX_out, busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: one-bit-per-clock UART transmitter (start, LSB-first data, optional parity, stop)
//   clk, rst : clock, asynchronous active-high reset
//   bus      : P_DATA/data_valid/PAR_EN/PAR_TYP in, registered TX_out/busy out
module uart_tx #(parameter int DATA_WIDTH = 8) (
  input logic clk,
  input logic rst,
  uart_tx_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic par_en_q, par_en_d, par_q, par_d, tx_q, tx_d, busy_q, busy_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end
  // tx_d is the bit the line carries in the state being entered, so outputs stay registered
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: if (bus.data_valid) begin
        state_d  = START;
        shift_d  = bus.P_DATA;
        par_en_d = bus.PAR_EN;
        par_d    = ^bus.P_DATA ^ bus.PAR_TYP;
        tx_d     = 1'b0;
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (cnt_q == CW'(DATA_WIDTH - 1)) begin
        state_d = par_en_q ? PARITY : STOP;
        tx_d    = par_en_q ? par_q : 1'b1;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      PARITY: state_d = STOP;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  assign bus.TX_out = tx_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed scoreboard bench for uart_tx
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic q[$];
  int n_chk = 0;
  int n_fail = 0;
  uart_tx_if #(.DATA_WIDTH(8)) bus();
  uart_tx #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", bus.TX_out, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
    end
  endtask
  // Called on a falling edge; inj>=0 pulses a competing request mid-frame, abort>=0 resets mid-frame
  task automatic frame(input logic [7:0] d, input logic pe, input logic pt, input int inj, input int abort);
    int len;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back(^d ^ pt);
    q.push_back(1'b1);
    len = q.size();
    bus.P_DATA = d;
    bus.PAR_EN = pe;
    bus.PAR_TYP = pt;
    bus.data_valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.data_valid = (i == inj);
      if (i == inj) begin
        bus.P_DATA = 8'h3C;
        bus.PAR_EN = ~pe;
        bus.PAR_TYP = ~pt;
      end
      if (i == abort) begin
        rst = 1'b1;
        #1;
        check("abort_tx", bus.TX_out, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      check("frame_tx", bus.TX_out, q.pop_front());
      check("frame_busy", bus.busy, 1'b1);
    end
    @(negedge clk);
    bus.data_valid = 1'b0;
    check("end_tx", bus.TX_out, 1'b1);
    check("end_busy", bus.busy, 1'b0);
  endtask
  initial begin
    bus.P_DATA = '0;
    bus.data_valid = 1'b0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", bus.TX_out, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    idle(1);
    frame(8'hA5, 1'b1, 1'b0, -1, -1);
    frame(8'h5A, 1'b1, 1'b1, -1, -1);
    frame(8'hB7, 1'b0, 1'b0, -1, -1);
    idle(10);
    frame(8'hA5, 1'b1, 1'b0, 4, -1);
    idle(12);
    frame(8'hC3, 1'b1, 1'b0, -1, 5);
    idle(1);
    frame(8'h96, 1'b1, 1'b1, -1, -1);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serializes one byte per request into a standard asynchronous frame: start bit, data LSB first, optional parity bit, stop bit. It transmits one bit per clock, so the baud tick equals the clock. It sits between a parallel producer that issues a one-cycle `data_valid` strobe and the serial line. A `busy` output tells the producer when a new request will be accepted.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset: one clock; reset is asynchronous and active-high
P_DATA  input  DATA_WIDTH  byte to transmit; sampled on the accepting edge
data_valid  input  1  request strobe; one cycle high is sufficient
PAR_EN  input  1  1 = insert parity bit; sampled on the accepting edge
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on the accepting edge
TX_out  output  1  serial line; idles high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (rst=1, asynchronous):
  - state = IDLE, TX_out = 1, busy = 0.
  - Internal shift register, bit counter and latched config cleared.
  - Asserting reset mid-frame aborts the frame immediately; the line returns high.
- Outputs TX_out and busy are registered; they change only on rising clk (or on reset).
- FSM states: IDLE -> START -> DATA -> PARITY (only if the latched PAR_EN=1) -> STOP -> IDLE.
- IDLE:
  - TX_out = 1, busy = 0.
  - On a rising edge with data_valid=1: latch P_DATA, PAR_EN and PAR_TYP; compute parity; go to START.
  - On that same edge, TX_out becomes 0 and busy becomes 1.
- START: exactly 1 cycle with TX_out = 0.
- DATA: DATA_WIDTH cycles, transmitting P_DATA[0] first and P_DATA[DATA_WIDTH-1] last.
- PARITY: 1 cycle.
  - Even (PAR_TYP=0): TX_out = XOR of all latched data bits.
  - Odd (PAR_TYP=1): TX_out = inverted XOR.
- STOP: 1 cycle with TX_out = 1. Next edge returns to IDLE, with TX_out = 1 and busy = 0.
- Frame length:
  - 11 cycles with parity, 10 without (for DATA_WIDTH=8).
  - The frame occupies cycles N+1 .. N+11 (or N+10), where edge N is the one that accepted data_valid.
- data_valid while busy=1 is ignored, and the request is lost.
  - Changes to P_DATA, PAR_EN or PAR_TYP during a frame do not affect it.
- A request in the cycle right after STOP (state back in IDLE) is accepted. Minimum spacing between starts is one full frame plus one idle cycle.
- Parity is computed from the latched data, so the value transmitted is fixed at acceptance.

Test Plan:
1. Reset, then PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, data_valid pulsed for 1 cycle -> busy=1 the cycle after acceptance. TX_out over 11 cycles = 0, 1,0,1,0,0,1,0,1, 0, 1 (start, LSB-first data, even parity 0, stop).
2. Immediately afterwards, PAR_TYP=1, P_DATA=0x5A -> TX_out = 0, 0,1,0,1,1,0,1,0, 1, 1 (odd parity 1). busy drops after the stop bit.
3. PAR_EN=0, P_DATA=0xB7 -> 10-bit frame 0, 1,1,1,0,1,1,0,1, 1. The line stays 1 afterwards and busy=0 in the 11th cycle.
4. data_valid held low after a frame -> TX_out stays 1 and busy stays 0 indefinitely.
5. Pulse data_valid with P_DATA=0x3C mid-frame of a 0xA5 transfer -> the 0xA5 frame completes unaltered and no 0x3C frame follows.
6. Assert rst during DATA of a frame -> TX_out=1 and busy=0 immediately. A new request after reset release sends a complete, correct frame.
